// File: rtl/seq_add_pkg.sv
// Shared types and constants for the sliced sequential adder.
package seq_add_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_add32_ctrl_add8.sv
// 8-bit combinational ripple-carry adder built as an explicit full-adder chain.
module add8
  import seq_add_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W:0] carry;

  // Full-adder chain, bit 0 fed by cin, carry rippling upward.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < SLICE_W; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[SLICE_W];
  end

endmodule

// File: rtl/seq_add32_ctrl.sv
// Sequential adder: one 8-bit adder reused over NSLICE cycles, valid/ready on both sides.
//
// state | meaning
// IDLE  | ready for operands; last result held on sum/cout/ovf
// ADD   | one slice per cycle through the shared add8, LSB slice first
// DONE  | result complete; offered on out_valid until out_ready
//
// The first DONE cycle only settles the result; out_valid rises on the
// following edge, giving an accept-to-valid distance of NSLICE+1 edges.
module seq_add32_ctrl
  import seq_add_pkg::*;
#(
  parameter int NSLICE = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SLICE_W*NSLICE-1:0] a,
  input  logic [SLICE_W*NSLICE-1:0] b,
  input  logic                      cin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SLICE_W*NSLICE-1:0] sum,
  output logic                      cout,
  output logic                      ovf,
  output logic                      busy
);

  localparam int W     = SLICE_W * NSLICE;
  localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_t             state_q;
  state_t             state_d;
  logic [W-1:0]       a_r;
  logic [W-1:0]       b_r;
  logic               carry_r;
  logic [IDX_W-1:0]   idx;
  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic [SLICE_W-1:0] add_sum;
  logic               add_cout;
  logic               last_slice;

  assign last_slice = (idx == LAST_IDX);
  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);

  // Select the operand slices addressed by idx.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx == IDX_W'(i)) begin
        a_sl = a_r[i*SLICE_W +: SLICE_W];
        b_sl = b_r[i*SLICE_W +: SLICE_W];
      end
    end
  end

  add8 u_add8 (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry_r),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)              state_d = ADD;
      ADD:     if (last_slice)            state_d = DONE;
      DONE:    if (out_valid && out_ready) state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  // Operand capture, slice accumulation and result handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r       <= '0;
      b_r       <= '0;
      carry_r   <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          out_valid <= 1'b0;
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            idx     <= '0;
          end
        end
        ADD: begin
          for (int i = 0; i < NSLICE; i++) begin
            if (idx == IDX_W'(i)) sum[i*SLICE_W +: SLICE_W] <= add_sum;
          end
          carry_r <= add_cout;
          if (last_slice) begin
            idx  <= '0;
            cout <= add_cout;
            ovf  <= (a_sl[SLICE_W-1] == b_sl[SLICE_W-1]) &&
                    (add_sum[SLICE_W-1] != a_sl[SLICE_W-1]);
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          out_valid <= !(out_valid && out_ready);
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_add32_ctrl.sv
// Scoreboard bench for seq_add32_ctrl: expected results queued at issue, popped by a monitor at each output handshake.
module tb_seq_add32_ctrl;

  localparam int NSLICE = 4;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int   n_checks;
  int   n_fail;
  res_t exp_q[$];

  seq_add32_ctrl #(.NSLICE(NSLICE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one operand set; optionally queue its expected result; check ADD-phase flags and latency.
  task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                      input logic [31:0] es, input logic ec, input logic eo);
    int   k;
    res_t r;
    k = 0;
    while (!in_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    r.sum = es; r.cout = ec; r.ovf = eo;
    exp_q.push_back(r);
    @(posedge clk); #1;
    // Garbage operands with in_valid held high for a few ADD cycles must be ignored.
    a = ~va; b = ~vb; cin = ~vc;
    chk("busy_in_add", {31'd0, busy}, 32'd1);
    chk("in_ready_in_add", {31'd0, in_ready}, 32'd0);
    k = 0;
    while (!out_valid && k < 20) begin
      in_valid = (k < 3);
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b0;
    chk("latency_edges", k, NSLICE + 1);
  endtask

  initial begin
    int   k;
    int   seen;
    res_t got;
    res_t want;

    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0;

    // Monitor: compare every accepted result against the head of the scoreboard.
    fork
      forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", sum, 32'hDEADBEEF);
          end else begin
            want = exp_q.pop_front();
            got.sum = sum; got.cout = cout; got.ovf = ovf;
            chk("result_sum", got.sum, want.sum);
            chk("result_cout", {31'd0, got.cout}, {31'd0, want.cout});
            chk("result_ovf", {31'd0, got.ovf}, {31'd0, want.ovf});
          end
        end
      end
    join_none

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    // Directed vectors, consumer always ready.
    send(32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    send(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0);

    // Result held in IDLE until overwritten.
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("idle_hold_sum", sum, 32'hACF1_3568);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Backpressure: consumer stalls in DONE while new operands are waved at the block.
    out_ready = 1'b0;
    send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a = 32'h5555_0000 + i; b = 32'hAAAA_0000 + i; cin = i[0];
      @(posedge clk); #1;
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_sum_stable", sum, 32'h0001_0000);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of ADD, after two slices have been processed.
    a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_sum", sum, 32'd0);
    chk("abort_cout", {31'd0, cout}, 32'd0);
    chk("abort_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    seen = 0;
    for (k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    chk("abort_no_valid", seen, 0);

    // Normal operation resumes after the abort.
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
